// File: rtl/vehicle_detect.sv
// ---------------------------------------------------------------------------
// vehicle_detect
//
// Turns a raw, asynchronous inductive-loop signal into a clean vehicle
// request for the downstream traffic-light FSM.
//
//   loop_raw -> 2-flop synchronizer -> debounce FSM -> arrival pulse
//   arrival  -> latched sensor request (cleared when the light goes GREEN)
//   arrival  -> saturating 8-bit arrival counter
//   clean    -> stuck-loop watchdog -> sticky fault (forces sensor high)
//
// Parameters
//   DEBOUNCE_CYCLES : stable synchronized samples needed to accept a level
//                     change (2..255)
//   STUCK_CYCLES    : consecutive debounced-high cycles that declare the loop
//                     stuck (> DEBOUNCE_CYCLES, up to 65535)
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   loop_raw  in   raw loop detector, asynchronous, 1 = vehicle present
//   light     in   [1:0] current light: 00 RED, 01 GREEN, 10 YELLOW, 11 invalid
//   sensor    out  latched vehicle request (flop output)
//   fault     out  sticky stuck-loop indication (flop output)
//   det_count out  [7:0] saturating count of accepted arrivals (flop output)
// ---------------------------------------------------------------------------
module vehicle_detect #(
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int STUCK_CYCLES    = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       loop_raw,
   input  logic [1:0] light,
   output logic       sensor,
   output logic       fault,
   output logic [7:0] det_count
);

   localparam logic [7:0]  DEB_C   = 8'(DEBOUNCE_CYCLES);
   localparam logic [15:0] STUCK_C = 16'(STUCK_CYCLES);
   localparam logic [1:0]  LIGHT_GREEN = 2'b01;

   typedef enum logic [1:0] {
      LO     = 2'd0,
      CHK_HI = 2'd1,
      HI     = 2'd2,
      CHK_LO = 2'd3
   } deb_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic        sync1_q;
   logic        sync_q;
   deb_state_e  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] stuck_q, stuck_d;
   logic        fault_q, fault_d;
   logic        sensor_q, sensor_d;
   logic [7:0]  count_q, count_d;
   logic        arrival;
   logic        clean;

   // Synchronizer: the only logic that ever samples loop_raw.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync_q  <= 1'b0;
      end else begin
         sync1_q <= loop_raw;
         sync_q  <= sync1_q;
      end
   end

   // Debounce FSM. The CHK states count consecutive samples at the new
   // level; a single sample back at the old level abandons the change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      arrival = 1'b0;
      case (state_q)
         LO: begin
            if (sync_q) begin
               state_d = CHK_HI;
               cnt_d   = 8'd1;
            end
         end
         CHK_HI: begin
            if (!sync_q) begin
               state_d = LO;
               cnt_d   = 8'd0;
            end else if (cnt_q == DEB_C) begin
               state_d = HI;
               cnt_d   = 8'd0;
               arrival = 1'b1;
            end else begin
               // cnt_q < DEB_C <= 255 here, so this cannot wrap
               cnt_d = cnt_q + 8'd1;
            end
         end
         HI: begin
            if (!sync_q) begin
               state_d = CHK_LO;
               cnt_d   = 8'd1;
            end
         end
         CHK_LO: begin
            if (sync_q) begin
               state_d = HI;
               cnt_d   = 8'd0;
            end else if (cnt_q == DEB_C) begin
               state_d = LO;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = LO;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign clean = (state_q == HI) || (state_q == CHK_LO);

   // Watchdog, request latch and arrival counter.
   always_comb begin
      stuck_d  = clean ? sat_inc16(stuck_q) : 16'd0;
      fault_d  = fault_q | (stuck_q == STUCK_C);
      count_d  = arrival ? sat_inc8(count_q) : count_q;
      sensor_d = sensor_q;
      // fault_d rather than fault_q so sensor is never low while fault is high
      if (fault_d) begin
         sensor_d = 1'b1;
      end else if (light == LIGHT_GREEN) begin
         sensor_d = 1'b0;
      end else if (arrival) begin
         sensor_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LO;
         cnt_q    <= 8'd0;
         stuck_q  <= 16'd0;
         fault_q  <= 1'b0;
         sensor_q <= 1'b0;
         count_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         stuck_q  <= stuck_d;
         fault_q  <= fault_d;
         sensor_q <= sensor_d;
         count_q  <= count_d;
      end
   end

   assign sensor    = sensor_q;
   assign fault     = fault_q;
   assign det_count = count_q;

endmodule

// File: doc/vehicle_detect.md
VEHICLE_DETECT -- requirements
Module: vehicle_detect

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 8: consecutive stable synchronized samples required to accept a level change (legal range 2..255).
REQ-002 The block SHALL have parameter STUCK_CYCLES, default 1024: consecutive cycles of debounced-high that declare the loop stuck (legal range > DEBOUNCE_CYCLES, up to 65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port loop_raw, input, 1 bit: asynchronous raw inductive-loop detector; 1 means vehicle present.
REQ-006 The block SHALL have port light, input, 2 bits: current light from the downstream traffic FSM; 00=RED, 01=GREEN, 10=YELLOW, 11=invalid.
REQ-007 The block SHALL have port sensor, output, 1 bit: latched vehicle request, driven straight from a flop into the traffic FSM sensor input.
REQ-008 The block SHALL have port fault, output, 1 bit: sticky stuck-loop indication.
REQ-009 The block SHALL have port det_count, output, 8 bits: saturating count of accepted vehicle arrivals.

Function
REQ-010 loop_raw SHALL pass through a 2-flop synchronizer, giving sync_q; no other logic SHALL sample loop_raw.
REQ-011 The debounce FSM SHALL have four states: LO, CHK_HI, HI and CHK_LO; clean = 1 in HI and CHK_LO only.
REQ-012 Debounce transitions SHALL be as follows:
- LO goes to CHK_HI when sync_q=1; the counter loads 1.
- CHK_HI increments while sync_q=1 and goes to HI when the counter reaches DEBOUNCE_CYCLES.
- CHK_HI returns to LO on any sync_q=0 sample.
- HI and CHK_LO mirror LO and CHK_HI with polarity inverted.
REQ-013 The debounce case SHALL have a default arm that forces LO; the unreachable encoding SHALL never stick.
REQ-014 An arrival SHALL be the CHK_HI to HI transition.
- On an arrival, sensor is set to 1 on the following edge.
- On an arrival, det_count increments and saturates at 255.
REQ-015 sensor SHALL clear on the edge after light==01 is sampled.
- If an arrival and light==01 occur in the same cycle, the clear wins: sensor=0 and det_count still increments.
REQ-016 sensor SHALL hold its value while light is 00, 10 or 11.
REQ-017 Arrival latency SHALL be fixed: with loop_raw stable high, first sampled high at edge k, sensor is 1 after edge k+2+DEBOUNCE_CYCLES.
REQ-018 A glitch on sync_q lasting fewer than DEBOUNCE_CYCLES samples SHALL cause no state change in sensor, det_count or fault.
REQ-019 A 16-bit stuck counter SHALL count consecutive cycles with clean=1 and SHALL reset to 0 whenever clean=0.
REQ-020 When the stuck counter reaches STUCK_CYCLES, fault SHALL set to 1 on the next edge and stay 1 until rst.
REQ-021 While fault=1, sensor SHALL be forced to 1 so that the traffic FSM keeps cycling (fail-safe).
- The light==01 clear is ignored while fault=1.
- Arrivals while fault=1 still count.
REQ-022 All outputs SHALL be registered; there SHALL be no combinational path from loop_raw or light to any output.

Reset
REQ-023 With rst=1 at an edge, the block SHALL clear the following on that edge:
- synchronizer flops to 0 and the debounce FSM to LO
- the debounce counter and stuck counter to 0
- sensor=0, fault=0 and det_count=0.
REQ-024 Reset SHALL take priority over every other event, including mid-debounce, a pending request and fault=1.
REQ-025 After rst deasserts, a loop_raw already high SHALL be treated as a fresh arrival, with full REQ-017 latency.

Verification (bench parameters: DEBOUNCE_CYCLES=4, STUCK_CYCLES=16)
REQ-026 Clean arrival: light=00, loop_raw rises before edge 0 and is held -> sensor=1 after edge 6, det_count=1.
REQ-027 Glitch rejection: loop_raw high for 3 cycles then low, repeated 5 times -> sensor stays 0 and det_count stays 0.
REQ-028 Acknowledge:
- Stimulus: sensor=1, light=10 for 5 cycles, then light=01 for 1 cycle.
- Response: sensor stays 1 through the light=10 cycles and is 0 after the edge that samples light=01.
- A second arrival during light=01 in the same cycle leaves sensor=0 and det_count=2.
REQ-029 Stuck loop:
- Stimulus: loop_raw held high for 30 cycles, then light=01.
- Response: fault=1 once the stuck counter reaches 16 (edge 23 from the first sample), and sensor stays 1 despite light=01.
- Then loop_raw=0 for 20 cycles: fault stays 1.
REQ-030 Saturation: 300 debounced pulses (high 6, low 6 cycles each) -> det_count=255 and never wraps to 0.
REQ-031 Reset mid-operation: rst=1 for one edge during CHK_HI and with fault=1 -> all outputs are 0 on the next cycle, and a held-high loop_raw gives sensor=1 six edges after rst deasserts.
